// File: rtl/data_sramlike_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the memory side (slave).
interface data_sramlike_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sramlike_bridge.sv
// MEM-stage to SRAM-like bus bridge: one outstanding access, pipeline stall, load extension.
// Optional access watchdog enabled by defining DSRAM_WATCHDOG_EN.
module data_sramlike_bridge (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_sram_enM,
  input  logic [3:0]                    memwriteM,
  input  logic [3:0]                    memReadWidthM,
  input  logic                          memLoadIsSignM,
  input  logic                          exceptM,
  input  logic [31:0]                   addrM,
  input  logic [31:0]                   wdataM,
  input  logic                          stall_other,
  data_sramlike_bridge_if.master        bus,
  output logic                          stall_req,
  output logic [31:0]                   rdataM,
  output logic                          wdog_err
);
  // state | meaning
  // IDLE  | no access in flight; request issued straight from MEM inputs
  // ADDR  | request held until the slave accepts the address
  // DATA  | address accepted, waiting for the data phase
  // DONE  | result presented; held while another stage stalls
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, stateNext;
  logic        discard, discardNext;
  logic [31:0] capWord;
  logic        idleReq, waiting, wdogFire, isWrite;
  logic [1:0]  sizeSel, loadSize;
  logic [31:0] shifted, loadExt;

  function automatic logic [1:0] maskSize(input logic [3:0] m);
    logic [2:0] ones;
    ones = {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    case (ones)
      3'd4:    return 2'd2;
      3'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  assign idleReq = (state == IDLE) && data_sram_enM && !exceptM;
  assign waiting = (state == ADDR) || (state == DATA);

`ifdef DSRAM_WATCHDOG_EN
  logic [7:0] wdogCnt;
  logic       wdogErrQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdogCnt  <= 8'd0;
      wdogErrQ <= 1'b0;
    end else begin
      wdogCnt <= waiting ? wdogCnt + 8'd1 : 8'd0;
      if (waiting && wdogCnt == 8'd254) wdogErrQ <= 1'b1;
    end
  end

  // error flag rises as the count lands on 255; the abort follows one cycle later
  assign wdogFire = waiting && (wdogCnt == 8'd255);
  assign wdog_err = wdogErrQ;
`else
  assign wdogFire = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      capWord <= 32'h0;
    end else begin
      state   <= stateNext;
      discard <= discardNext;
      if (state == DATA && bus.data_data_ok) capWord <= bus.data_rdata;
    end
  end

  always_comb begin
    stateNext   = state;
    discardNext = discard;
    case (state)
      IDLE: begin
        discardNext = 1'b0;
        if (idleReq) stateNext = bus.data_addr_ok ? DATA : ADDR;
      end
      ADDR:    if (bus.data_addr_ok) stateNext = DATA;
      DATA:    if (bus.data_data_ok) stateNext = DONE;
      DONE:    if (!stall_other) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // a flush seen mid-access lets the bus finish but drops the result
    if (waiting && exceptM) discardNext = 1'b1;
    if (wdogFire) begin
      stateNext   = DONE;
      discardNext = 1'b1;
    end
  end

  assign isWrite        = |memwriteM;
  assign sizeSel        = maskSize(isWrite ? memwriteM : memReadWidthM);
  assign loadSize       = maskSize(memReadWidthM);
  assign bus.data_req   = !rst && (idleReq || state == ADDR);
  assign stall_req      = !rst && (idleReq || waiting);
  assign bus.data_wr    = isWrite;
  assign bus.data_size  = sizeSel;
  assign bus.data_addr  = addrM;

  always_comb begin
    case (sizeSel)
      2'd0:    bus.data_wdata = {4{wdataM[7:0]}};
      2'd1:    bus.data_wdata = {2{wdataM[15:0]}};
      default: bus.data_wdata = wdataM;
    endcase
  end

  assign shifted = capWord >> {addrM[1:0], 3'b000};

  always_comb begin
    case (loadSize)
      2'd0:    loadExt = {{24{memLoadIsSignM & shifted[7]}}, shifted[7:0]};
      2'd1:    loadExt = {{16{memLoadIsSignM & shifted[15]}}, shifted[15:0]};
      default: loadExt = shifted;
    endcase
  end

  assign rdataM = (state == DONE && !discard && !exceptM && !isWrite) ? loadExt : 32'h0;
endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Randomized scoreboard bench for data_sramlike_bridge with a behavioural slave and load/store model.
module tb_data_sramlike_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  memwriteM, memReadWidthM;
  logic        memLoadIsSignM, exceptM, stall_other;
  logic [31:0] addrM, wdataM;
  logic        stall_req, wdog_err;
  logic [31:0] rdataM;

  logic        sAddrOk, sDataOk;
  logic [31:0] sRdata;
  int          cfgA, cfgD, txnId;
  logic [31:0] cfgRd;

  int nChecks = 0;
  int nPass = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busExp_t;

  typedef struct {
    int          op;   // 0 lb 1 lbu 2 lh 3 lhu 4 lw 5 sb 6 sh 7 sw
    logic [31:0] addr, wdata, rd;
    int          aDly, dDly, hold;
    bit          exc;
  } txn_t;

  busExp_t     expBus[$];
  logic [31:0] expRd[$];

  data_sramlike_bridge_if busIf();

  assign busIf.data_addr_ok = sAddrOk;
  assign busIf.data_data_ok = sDataOk;
  assign busIf.data_rdata   = sRdata;

  data_sramlike_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .data_sram_enM (en),
    .memwriteM     (memwriteM),
    .memReadWidthM (memReadWidthM),
    .memLoadIsSignM(memLoadIsSignM),
    .exceptM       (exceptM),
    .addrM         (addrM),
    .wdataM        (wdataM),
    .stall_other   (stall_other),
    .bus           (busIf),
    .stall_req     (stall_req),
    .rdataM        (rdataM),
    .wdog_err      (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    nChecks++;
    $display("FAIL %s: got no matching event, required one", name);
  endtask

  function automatic int nBytes(input int op);
    if (op == 0 || op == 1 || op == 5) return 1;
    if (op == 2 || op == 3 || op == 6) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] rd, input logic [1:0] off,
                                          input int n, input bit sg);
    logic [63:0] v, mask;
    v    = {32'h0, rd} >> (8 * off);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] expWdata(input logic [31:0] w, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input int a, input int d, input int hold,
                              input bit exc);
    txn_t t;
    t.op = op; t.addr = addr; t.wdata = wdata; t.rd = rd;
    t.aDly = a; t.dDly = d; t.hold = hold; t.exc = exc;
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    int n;
    logic [1:0] off;
    t.op  = $urandom_range(0, 7);
    n     = nBytes(t.op);
    off   = (n == 4) ? 2'd0 : (n == 2) ? {1'($urandom), 1'b0} : 2'($urandom);
    t.addr  = ($urandom & 32'hFFFF_FFFC) | {30'h0, off};
    t.wdata = $urandom;
    t.rd    = $urandom;
    t.aDly  = $urandom_range(0, 4);
    t.dDly  = $urandom_range(0, 4);
    t.hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
    t.exc   = ($urandom_range(0, 5) == 0);
    return t;
  endfunction

  // called #1 after a rising edge with the bridge in IDLE
  task automatic runTxn(input txn_t t);
    int n, nStall, nReq;
    bit st, sg;
    logic [3:0] m;
    busExp_t be;
    n  = nBytes(t.op);
    st = (t.op >= 5);
    sg = (t.op == 0 || t.op == 2);
    m  = ((n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111) << t.addr[1:0];
    en = 1'b1; addrM = t.addr; wdataM = t.wdata; exceptM = 1'b0;
    stall_other    = (t.hold > 0);
    memwriteM      = st ? m : 4'b0000;
    memReadWidthM  = st ? 4'($urandom) : m;
    memLoadIsSignM = st ? 1'($urandom) : sg;
    cfgA = t.aDly; cfgD = t.dDly; cfgRd = t.rd; txnId++;
    be.wr    = st;
    be.size  = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    be.addr  = t.addr;
    be.wdata = expWdata(t.wdata, n);
    expBus.push_back(be);
    expRd.push_back((st || t.exc) ? 32'h0 : expLoad(t.rd, t.addr[1:0], n, sg));
    nStall = 0; nReq = 0;
    while (1) begin
      @(negedge clk);
      if (nStall == 0) check("rdataIdle", rdataM, 32'h0);
      if (!stall_req) break;
      nStall++;
      if (busIf.data_req) nReq++;
      if (nStall > 300) begin failNow("txnTimeout"); break; end
      @(posedge clk); #1;
      if (t.exc) exceptM = 1'b1;
    end
    check("stallCycles", 32'(nStall), 32'(t.aDly + t.dDly + 2));
    check("reqCycles", 32'(nReq), 32'(t.aDly + 1));
    for (int i = 1; i < t.hold; i++) @(posedge clk);
    if (t.hold > 0) begin
      @(posedge clk); #1;
      stall_other = 1'b0;
    end
    @(posedge clk); #1;
    if (t.exc) begin
      @(negedge clk);
      check("reqAfterExc", {31'h0, busIf.data_req}, 32'h0);
      check("stallAfterExc", {31'h0, stall_req}, 32'h0);
      @(posedge clk); #1;
      exceptM = 1'b0;
      en      = 1'b0;
    end
  endtask

  // behavioural memory slave: programmed address/data latencies per transaction
  initial begin
    int aLeft, dLeft, lastId;
    bit pending, acceptedLast, dataOkLast;
    logic [31:0] word;
    sAddrOk = 1'b0; sDataOk = 1'b0; sRdata = 32'h0;
    aLeft = 0; dLeft = 0; lastId = 0; word = 32'h0;
    pending = 1'b0; acceptedLast = 1'b0; dataOkLast = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (acceptedLast) pending = 1'b1;
      if (dataOkLast) pending = 1'b0;
      if (txnId != lastId) begin
        lastId = txnId; aLeft = cfgA; dLeft = cfgD; word = cfgRd; pending = 1'b0;
      end
      sAddrOk = 1'b0; sDataOk = 1'b0; sRdata = $urandom;
      if (rst) pending = 1'b0;
      else if (pending) begin
        if (dLeft == 0) begin sDataOk = 1'b1; sRdata = word; end
        else dLeft--;
      end else if (busIf.data_req) begin
        if (aLeft == 0) sAddrOk = 1'b1;
        else aLeft--;
      end
      acceptedLast = sAddrOk && busIf.data_req;
      dataOkLast   = sDataOk;
    end
  end

  // monitor: pops expectations when the bridge accepts a request or presents a result
  initial begin
    bit dataOkSeen, inDone, doneSo;
    logic [31:0] doneVal, e;
    busExp_t be;
    dataOkSeen = 1'b0; inDone = 1'b0; doneSo = 1'b0; doneVal = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dataOkSeen = 1'b0; inDone = 1'b0;
        continue;
      end
      if (dataOkSeen) begin
        if (expRd.size() == 0) failNow("unexpectedCompletion");
        else begin
          e = expRd.pop_front();
          check("rdataM", rdataM, e);
          check("stallInDone", {31'h0, stall_req}, 32'h0);
          inDone = 1'b1; doneVal = e; doneSo = stall_other;
        end
      end else if (inDone) begin
        if (doneSo) begin
          check("rdataHold", rdataM, doneVal);
          check("stallHold", {31'h0, stall_req}, 32'h0);
          doneSo = stall_other;
        end else inDone = 1'b0;
      end
      if (busIf.data_req && busIf.data_addr_ok) begin
        if (expBus.size() == 0) failNow("unexpectedReq");
        else begin
          be = expBus.pop_front();
          check("wr", {31'h0, busIf.data_wr}, {31'h0, be.wr});
          check("size", {30'h0, busIf.data_size}, {30'h0, be.size});
          check("addr", busIf.data_addr, be.addr);
          check("wdata", busIf.data_wdata, be.wdata);
        end
      end
      dataOkSeen = busIf.data_data_ok;
    end
  end

  initial begin
    #500000;
    $display("FAIL globalTimeout: got no end of run, required completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    txnId = 0; cfgA = 0; cfgD = 0; cfgRd = 32'h0;
    rst = 1'b1; en = 1'b1; memwriteM = 4'h0; memReadWidthM = 4'hF; memLoadIsSignM = 1'b0;
    exceptM = 1'b0; stall_other = 1'b0; addrM = 32'h0; wdataM = 32'h0;
    @(negedge clk);
    check("rstReq", {31'h0, busIf.data_req}, 32'h0);
    check("rstStall", {31'h0, stall_req}, 32'h0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check("resetRdata", rdataM, 32'h0);
    check("resetWdog", {31'h0, wdog_err}, 32'h0);
    check("resetStall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1;

    runTxn(mk(4, 32'h0000_1000, 32'h0, 32'h8899_AABB, 0, 0, 0, 1'b0));
    runTxn(mk(0, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 1'b0));
    runTxn(mk(1, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 1'b0));
    runTxn(mk(6, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 0, 0, 1'b0));
    runTxn(mk(4, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 2, 5, 1'b0));
    runTxn(mk(4, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 1, 2, 0, 1'b1));
    runTxn(mk(2, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 0, 1, 0, 1'b0));
    en = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of an address wait abandons the access
    en = 1'b1; addrM = 32'h0000_6000; memwriteM = 4'h0; memReadWidthM = 4'hF;
    cfgA = 20; cfgD = 0; cfgRd = 32'h0; txnId++;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    check("midRstReq", {31'h0, busIf.data_req}, 32'h0);
    check("midRstStall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("postRstReq", {31'h0, busIf.data_req}, 32'h0);
    check("postRstRdata", rdataM, 32'h0);
    @(posedge clk); #1;

    for (int k = 0; k < 60; k++) begin
      runTxn(randTxn());
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0; exceptM = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("busQueueLeft", 32'(expBus.size()), 32'h0);
    check("rdQueueLeft", 32'(expRd.size()), 32'h0);

`ifdef DSRAM_WATCHDOG_EN
    begin
      int cnt;
      en = 1'b1; addrM = 32'h0000_7000; memwriteM = 4'h0; memReadWidthM = 4'hF;
      stall_other = 1'b0; exceptM = 1'b0;
      cfgA = 100000; cfgD = 0; cfgRd = 32'h0; txnId++;
      cnt = 0;
      while (1) begin
        @(negedge clk);
        if (wdog_err) break;
        if (stall_req) cnt++;
        if (cnt > 400) begin failNow("wdogTimeout"); break; end
      end
      check("wdogWaitCycles", 32'(cnt), 32'(1 + 255));
      check("wdogStallStillHigh", {31'h0, stall_req}, 32'h1);
      @(negedge clk);
      check("wdogStallDrop", {31'h0, stall_req}, 32'h0);
      check("wdogRdata", rdataM, 32'h0);
      check("wdogSticky", {31'h0, wdog_err}, 32'h1);
      @(posedge clk); #1; en = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("wdogClearedByRst", {31'h0, wdog_err}, 32'h0);
    end
`else
    check("wdogTiedLow", {31'h0, wdog_err}, 32'h0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/data_sramlike_bridge.md
DATA_SRAMLIKE_BRIDGE -- requirements
Module: data_sramlike_bridge

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs data_sram_enM (1, access valid in MEM), memwriteM (4, store byte mask), memReadWidthM (4, load byte mask), memLoadIsSignM (1) and exceptM (1, MEM exception/flush cancel).
REQ-004 SHALL have inputs addrM (32, effective address), wdataM (32, raw rt value) and stall_other (1, stall raised by any other source).
REQ-005 SHALL have bus outputs data_req (1), data_wr (1), data_size (2; 0=byte, 1=half, 2=word), data_addr (32) and data_wdata (32).
REQ-006 SHALL have bus inputs data_addr_ok (1), data_data_ok (1) and data_rdata (32).
REQ-007 SHALL have outputs stall_req (1, freeze pipeline), rdataM (32, extended load result) and wdog_err (1, sticky timeout).

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, DATA and DONE.
REQ-009 SHALL assert data_req = (IDLE & data_sram_enM & ~exceptM) | ADDR.
REQ-010 SHALL transition IDLE->DATA when data_req & data_addr_ok, IDLE->ADDR when data_req & ~data_addr_ok, and otherwise hold IDLE.
REQ-011 SHALL transition ADDR->DATA on data_addr_ok; ADDR SHALL hold data_req high regardless of exceptM (no request retraction).
REQ-012 SHALL transition DATA->DONE on data_data_ok and capture data_rdata in that cycle.
REQ-013 SHALL transition DONE->IDLE when ~stall_other; otherwise it SHALL hold DONE with rdataM stable.
REQ-014 SHALL assert stall_req = (IDLE & data_sram_enM & ~exceptM) | ADDR | DATA, with DONE deasserting it.
REQ-015 SHALL give a minimum of 3 cycles from entering IDLE with a request to stall_req low, when addr_ok arrives same-cycle and data_ok arrives the next cycle.
REQ-016 SHALL drive data_wr = |memwriteM.
REQ-017 SHALL derive data_size from the active mask (memwriteM if data_wr, else memReadWidthM): popcount 4->2, 2->1, 1->0.
REQ-018 SHALL drive data_addr = addrM unmodified.
REQ-019 SHALL form data_wdata as: byte {4{wdataM[7:0]}}, half {2{wdataM[15:0]}}, word wdataM.
REQ-020 SHALL form rdataM by right-shifting the captured word by 8*addrM[1:0] bits, then sign-extending (memLoadIsSignM=1) or zero-extending (=0) to 32 bits per the load width.
REQ-021 SHALL output rdataM = 0 for stores and in IDLE.
REQ-022 SHALL, when exceptM rises while in ADDR or DATA, complete the transaction, then in DONE force stall_req=0 and discard the result (rdataM=0).
REQ-023 SHALL treat a DONE->IDLE transition with data_sram_enM still high (next instruction) as a fresh request starting that cycle in IDLE.
REQ-024 SHALL hold all bus attributes stable while data_req=1, relying on stall_req freezing the MEM inputs.

Reset
REQ-025 SHALL on rst=1 at a clock edge set state=IDLE, the captured rdata register=0, the watchdog count=0 and wdog_err=0.
REQ-026 SHALL, while rst=1, drive data_req=0 and stall_req=0; a reset mid-transaction abandons it with no completion.

Configuration
REQ-027 SHALL, with DSRAM_WATCHDOG_EN defined, run an 8-bit counter incremented each cycle in ADDR or DATA and cleared on any other state.
REQ-028 SHALL, on that counter reaching 255, set wdog_err=1 (sticky until rst) and force the FSM to DONE with rdataM=0.
REQ-029 SHALL, without DSRAM_WATCHDOG_EN, omit the counter, tie wdog_err=0 and wait indefinitely in ADDR and DATA.

Verification
REQ-030 SHALL cover: lw addr 0x1000, addr_ok same cycle, data_ok +1, rdata 0x8899AABB -> req 1 cycle, size=2, stall_req high 2 cycles, rdataM=0x8899AABB.
REQ-031 SHALL cover: lb signed addr 0x1003, rdata 0x80FF_FF7F -> size=0, rdataM=0xFFFFFF80; lbu same -> 0x00000080.
REQ-032 SHALL cover: sh addr 0x2002, wdataM 0x1234ABCD, addr_ok delayed 3 cycles -> data_req held 4 cycles, wr=1, size=1, wdata=0xABCDABCD.
REQ-033 SHALL cover: data_ok arrives while stall_other=1 for 5 cycles -> DONE held 5 cycles, rdataM stable, stall_req=0.
REQ-034 SHALL cover: exceptM asserted in DATA -> transaction completes on data_ok, rdataM=0, no new request issued.
REQ-035 SHALL cover (DSRAM_WATCHDOG_EN): addr_ok never asserted -> wdog_err=1 after 255 cycles, stall_req drops next cycle.
